fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the async FIFO write side among N_REQ requesters in the write clock domain.
- Grants one requester at a time for a burst, terminated by req_last or by the MAX_BURST beat limit.
- Drives w_inc/w_data into the FIFO write logic and honours its full flag so no beat is lost or overwritten.

Parameters:
N_REQ, 4, number of requesters (2..8)
D_WIDTH, 8, FIFO data word width
MAX_BURST, 8, max beats per grant before forced re-arbitration (>=1)

Ports:
w_clk  input  1  write-domain clock, all logic on rising edge
w_rst  input  1  synchronous, active-high reset
req_valid  input  N_REQ  per-requester beat valid
req_data  input  N_REQ*D_WIDTH  packed beats, requester i at [i*D_WIDTH +: D_WIDTH]
req_last  input  N_REQ  final beat of requester's burst
req_ready  output  N_REQ  beat accepted this cycle (one-hot or zero)
full  input  1  FIFO full flag from write pointer logic
w_inc  output  1  FIFO write enable
w_data  output  D_WIDTH  FIFO write data
grant_id  output  $clog2(N_REQ)  currently granted requester (registered)
busy  output  1  high while in GRANT state (registered)

Behaviour:
- Reset (w_rst=1 at rising edge): state=IDLE, grant_id=0, busy=0, rr_ptr=0, beat_cnt=0. Combinational outputs (req_ready, w_inc) are 0 because busy=0, and w_data=0. Reset mid-burst aborts the burst immediately; no partial-burst memory.
- Handshake: a transfer occurs when req_valid[g] && req_ready[g].
  - req_ready[g] = busy && !full; all other bits 0.
  - w_inc = busy && req_valid[g] && !full.
  - w_data = req_data[g] when busy, else 0.
  - All three are combinational from registered state, so there is no extra latency from full to stall.
- IDLE:
  - If no req_valid, stay.
  - Otherwise pick the first set req_valid at or after rr_ptr, scanning upward and wrapping modulo N_REQ.
  - Next cycle: state=GRANT, grant_id=winner, busy=1, beat_cnt=0, rr_ptr=(winner+1) mod N_REQ.
  - Arbitration latency is 1 cycle; no beat transfers in IDLE.
- GRANT:
  - Each transfer increments beat_cnt.
  - The burst ends on a transfer with req_last[g]=1 or with beat_cnt==MAX_BURST-1. At the following edge: state=IDLE, busy=0.
  - One idle cycle separates consecutive bursts.
  - A forced end at MAX_BURST without last: the requester re-competes and resumes only when rr order returns to it.
- Stall rules:
  - full=1 blocks the transfer; state and beat_cnt hold, and data stays on req_data (requester must hold it).
  - req_valid[g]=0 in GRANT: no transfer, grant held. Requesters must keep valid asserted until last.
  - Requests from non-granted requesters are ignored in GRANT, and req_last on them has no effect.
- Simultaneous events:
  - last and MAX_BURST on the same beat give a single burst end.
  - full rising in the same cycle as a last beat stalls that beat; the burst ends only when it transfers.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,...; worst-case wait is (N_REQ-1) bursts.
- Widths:
  - beat_cnt is $clog2(MAX_BURST)+1 bits, never wraps (reset on grant).
  - rr_ptr and grant_id are $clog2(N_REQ) bits; the N_REQ=2 case gives 1 bit.

Decomposition:
- Shared package fifo_pkg:
  - D_WIDTH default constant.
  - State enum {IDLE, GRANT}.
  - Function clog2 for pointer and counter widths.
- Sub-module rr_pick: combinational round-robin priority selector.
  - Inputs: req vector, rr_ptr.
  - Outputs: any, winner index.
  - Instantiated once; rotate, find-first, un-rotate.
- The FSM, counter and output muxing stay in fifo_wr_arbiter.

Test Plan:
- Reset: hold w_rst high with all req_valid=1 -> busy=0, w_inc=0, req_ready=0, grant_id=0. Release -> grant to 0 appears one cycle later, busy=1.
- Single burst: req 2 sends 3 beats A1,A2,A3 with last on A3, full=0 -> grant_id=2, w_inc high 3 consecutive cycles with w_data A1,A2,A3, then busy=0 next cycle.
- Round-robin: reqs 0,1,3 all valid with 1-beat bursts (last=1) -> grant order 0,1,3,0,1,3. Each burst takes 2 cycles (grant plus beat).
- MAX_BURST=8: req 1 streams 20 beats without last, req 0 also valid -> burst of exactly 8 beats on req1, then req 0 served, then req 1 resumes.
- Full backpressure: during req 3 burst, assert full for 4 cycles after beat 2 -> w_inc=0 and req_ready=0 for those 4 cycles, grant_id stays 3. Beat 3 is written on the first cycle with full=0 and no beat is duplicated.
- Mid-burst reset: assert w_rst after beat 1 of a 5-beat burst -> next cycle busy=0, rr_ptr=0. The new arbitration starts from requester 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_pkg;

    localparam int D_WIDTH_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Bits needed to index v items; constant-evaluated for widths only.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin priority selector: rotate by rr_ptr, find first set, un-rotate.
module rr_pick
    import fifo_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] rr_ptr,
    output logic         any,
    output logic [W-1:0] winner
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             k;

    always_comb begin
        dbl = {req, req} >> rr_ptr;
        rot = dbl[N-1:0];
        any = |req;
        k   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) k = i;
        end
        winner = W'((int'(rr_ptr) + k) % N);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port between N_REQ burst requesters.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int D_WIDTH   = D_WIDTH_DEF,
    parameter int MAX_BURST = 8
) (
    input  logic                       w_clk,
    input  logic                       w_rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*D_WIDTH-1:0]   req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       full,
    output logic                       w_inc,
    output logic [D_WIDTH-1:0]         w_data,
    output logic [clog2(N_REQ)-1:0]    grant_id,
    output logic                       busy
);

    localparam int GW = clog2(N_REQ);
    localparam int CW = clog2(MAX_BURST) + 1;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

    logic            pick_any;
    logic [GW-1:0]   pick_idx;
    logic            sel_valid;
    logic            sel_last;
    logic [D_WIDTH-1:0] sel_data;
    logic            xfer;

    rr_pick #(
        .N (N_REQ),
        .W (GW)
    ) u_rr_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .any    (pick_any),
        .winner (pick_idx)
    );

    // Outputs come straight from registered grant state so full stalls with no added latency.
    always_comb begin
        busy      = (state_q == GRANT);
        sel_valid = req_valid[grant_id_q];
        sel_last  = req_last[grant_id_q];
        sel_data  = req_data[int'(grant_id_q)*D_WIDTH +: D_WIDTH];
        xfer      = busy && sel_valid && !full;
        req_ready = '0;
        if (busy && !full) req_ready[grant_id_q] = 1'b1;
        w_inc     = xfer;
        w_data    = busy ? sel_data : '0;
        grant_id  = grant_id_q;
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = GRANT;
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                    rr_ptr_d   = (pick_idx == GW'(N_REQ - 1)) ? '0 : pick_idx + GW'(1);
                end
            end
            GRANT: begin
                if (xfer) begin
                    if (sel_last || beat_cnt_q == CW'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic against a queue-based reference.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 8;

    logic            w_clk = 1'b0;
    logic            w_rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            full;
    logic            w_inc;
    logic [DW-1:0]   w_data;
    logic [1:0]      grant_id;
    logic            busy;

    fifo_wr_arbiter #(.N_REQ(N), .D_WIDTH(DW), .MAX_BURST(MB)) dut (
        .w_clk     (w_clk),
        .w_rst     (w_rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .full      (full),
        .w_inc     (w_inc),
        .w_data    (w_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 w_clk = ~w_clk;

    int tests = 0;
    int fails = 0;

    // Pending beats per requester, packed as {last, data}.
    logic [8:0] q [N][$];
    int         grant_log[$];
    int         len_log[$];
    int         wr_log[$];
    int         push_log[$];
    int         data_ctr = 1;

    // Reference: abstract arbiter state.
    bit m_busy;
    int m_grant, m_rr, m_beats;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input int r, input int len);
        for (int i = 0; i < len; i++) begin
            q[r].push_back({(i == len - 1), 8'(data_ctr)});
            push_log.push_back(data_ctr % 256);
            data_ctr++;
        end
    endtask

    task automatic clear_logs();
        grant_log.delete();
        len_log.delete();
        wr_log.delete();
        push_log.delete();
    endtask

    task automatic step(input bit rst, input bit f);
        bit         xfer;
        logic [8:0] b;
        @(negedge w_clk);
        w_rst = rst;
        full  = f;
        for (int r = 0; r < N; r++) begin
            if (q[r].size() > 0) begin
                b = q[r][0];
                req_valid[r]           = 1'b1;
                req_data[r*DW +: DW]   = b[7:0];
                req_last[r]            = b[8];
            end else begin
                req_valid[r]           = 1'b0;
                req_data[r*DW +: DW]   = 8'($urandom);
                req_last[r]            = 1'($urandom);
            end
        end
        #1;
        xfer = m_busy && req_valid[m_grant] && !f;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("grant_id", 32'(grant_id), 32'(m_grant));
        chk("w_inc", 32'(w_inc), 32'(xfer));
        chk("req_ready", 32'(req_ready), (m_busy && !f) ? (32'd1 << m_grant) : 32'd0);
        chk("w_data", 32'(w_data), m_busy ? 32'(req_data[m_grant*DW +: DW]) : 32'd0);
        @(posedge w_clk);
        if (xfer) begin
            b = q[m_grant].pop_front();
            wr_log.push_back(int'(b[7:0]));
            m_beats++;
            if (b[8] || m_beats == MB) begin
                m_busy = 1'b0;
                len_log.push_back(m_beats);
            end
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                if (!m_busy && req_valid[(m_rr + k) % N]) begin
                    m_busy  = 1'b1;
                    m_grant = (m_rr + k) % N;
                    m_rr    = (m_grant + 1) % N;
                    m_beats = 0;
                    grant_log.push_back(m_grant);
                end
            end
        end
        if (rst) begin
            m_busy = 1'b0; m_grant = 0; m_rr = 0; m_beats = 0;
        end
    endtask

    task automatic flush_queues();
        for (int r = 0; r < N; r++) q[r].delete();
    endtask

    function automatic int pending();
        int s = 0;
        for (int r = 0; r < N; r++) s += q[r].size();
        return s;
    endfunction

    initial begin
        int exp_rr[6];
        int exp_mb[4];
        int exp_ml[4];
        int budget;
        w_rst = 1'b1; full = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
        m_busy = 1'b0; m_grant = 0; m_rr = 0; m_beats = 0;

        // Reset held with every requester valid: nothing may be granted.
        for (int r = 0; r < N; r++) push_burst(r, 1);
        repeat (3) step(1'b1, 1'b0);
        clear_logs();
        step(1'b0, 1'b0);
        chk("rst_first_grant_cnt", 32'(grant_log.size()), 32'd1);
        if (grant_log.size() > 0) chk("rst_first_grant", 32'(grant_log[0]), 32'd0);
        repeat (10) step(1'b0, 1'b0);
        chk("rst_drain", 32'(pending()), 32'd0);

        // Single burst of three beats on requester 2.
        step(1'b1, 1'b0);
        clear_logs();
        push_burst(2, 3);
        repeat (6) step(1'b0, 1'b0);
        chk("single_grant", 32'(grant_log.size() == 1 ? grant_log[0] : -1), 32'd2);
        chk("single_len", 32'(wr_log.size()), 32'd3);
        chk("single_data", 32'(wr_log == push_log), 32'd1);

        // Round-robin with 1-beat bursts on 0,1,3.
        step(1'b1, 1'b0);
        clear_logs();
        for (int i = 0; i < 2; i++) begin
            push_burst(0, 1); push_burst(1, 1); push_burst(3, 1);
        end
        repeat (12) step(1'b0, 1'b0);
        chk("rr_done", 32'(pending()), 32'd0);
        exp_rr = '{0, 1, 3, 0, 1, 3};
        chk("rr_cnt", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk("rr_order", 32'(grant_log[i]), 32'(exp_rr[i]));

        // MAX_BURST cut: requester 1 streams 20 beats, requester 0 joins.
        step(1'b1, 1'b0);
        clear_logs();
        push_burst(1, 20);
        step(1'b0, 1'b0);
        push_burst(0, 2);
        budget = 0;
        while (pending() > 0 && budget < 100) begin
            step(1'b0, 1'b0);
            budget++;
        end
        repeat (2) step(1'b0, 1'b0);
        chk("mb_timeout", 32'(budget < 100), 32'd1);
        exp_mb = '{1, 0, 1, 1};
        exp_ml = '{8, 2, 8, 4};
        chk("mb_cnt", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk("mb_order", 32'(grant_log[i]), 32'(exp_mb[i]));
        for (int i = 0; i < 4 && i < len_log.size(); i++)
            chk("mb_len", 32'(len_log[i]), 32'(exp_ml[i]));

        // Full backpressure after beat 2 of a 5-beat burst on requester 3.
        step(1'b1, 1'b0);
        clear_logs();
        push_burst(3, 5);
        repeat (3) step(1'b0, 1'b0);
        chk("full_pre_beats", 32'(wr_log.size()), 32'd2);
        repeat (4) step(1'b0, 1'b1);
        chk("full_hold_beats", 32'(wr_log.size()), 32'd2);
        repeat (4) step(1'b0, 1'b0);
        chk("full_data", 32'(wr_log == push_log), 32'd1);

        // Mid-burst reset: arbitration restarts from requester 0.
        step(1'b1, 1'b0);
        push_burst(3, 1);
        repeat (3) step(1'b0, 1'b0);
        clear_logs();
        push_burst(2, 5);
        repeat (2) step(1'b0, 1'b0);
        push_burst(0, 1);
        step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0);
        chk("mrst_cnt", 32'(grant_log.size()), 32'd3);
        if (grant_log.size() >= 3) begin
            chk("mrst_g0", 32'(grant_log[0]), 32'd2);
            chk("mrst_g1", 32'(grant_log[1]), 32'd0);
            chk("mrst_g2", 32'(grant_log[2]), 32'd2);
        end
        chk("mrst_drain", 32'(pending()), 32'd0);

        // Random traffic with random full.
        step(1'b1, 1'b0);
        flush_queues();
        for (int c = 0; c < 800; c++) begin
            int r;
            r = $urandom_range(N - 1);
            if (q[r].size() == 0 && $urandom_range(3) == 0) push_burst(r, $urandom_range(12, 1));
            step(1'b0, ($urandom_range(3) == 0));
        end
        budget = 0;
        while (pending() > 0 && budget < 400) begin
            step(1'b0, 1'b0);
            budget++;
        end
        chk("rand_drain", 32'(pending()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
